bram_wr_accessor: RTL and testbench

Stream-to-BRAM write engine, the write-side counterpart of the BRAM read accessor. On `start_i` it captures a word count and a base address. It then accepts exactly that many words over a valid/ready input stream and drives the BRAM write port with sequential addresses. A one-cycle `done_o` pulse marks the end of the burst, and the block returns to idle.

---
 rtl/bram_wr_accessor.sv | 152 +++++++++++++++
 tb/tb_bram_wr_accessor.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_wr_accessor.sv
// bram_wr_accessor: stream-to-BRAM write engine.
// On start_i it captures a word count and a base address. It then accepts that many
// words over a valid/ready stream and writes them to sequential BRAM addresses.
// done_o pulses for one cycle when the burst ends.
// Optional feature macro: BRAM_WR_CHECKSUM_EN adds checksum_o, the running sum of the
// accepted words modulo 2^DWIDTH.
module bram_wr_accessor #(
  parameter int DWIDTH  = 32,
  parameter int AWIDTH  = 12,
  parameter int CNT_BIT = 31
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [CNT_BIT-1:0] num_i,
  input  logic [AWIDTH-1:0]  base_addr_i,
  input  logic               s_valid_i,
  output logic               s_ready_o,
  input  logic [DWIDTH-1:0]  s_data_i,
  output logic [AWIDTH-1:0]  addr_o,
  output logic               ce_o,
  output logic               we_o,
  output logic [DWIDTH-1:0]  d_o,
`ifdef BRAM_WR_CHECKSUM_EN
  output logic [DWIDTH-1:0]  checksum_o,
`endif
  output logic               idle_o,
  output logic               run_o,
  output logic               done_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  state_e             c_state_q, n_state_d;
  logic [CNT_BIT-1:0] num_q, num_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0]  base_q, base_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic               beat;
  logic               last_beat;
  logic               start_take;

  // A beat is a handshake in RUN; the last one is the beat at count num_q-1.
  assign beat       = s_valid_i && (c_state_q == RUN);
  assign last_beat  = beat && (cnt_q == (num_q - CNT_BIT'(1)));
  assign start_take = start_i && (c_state_q == IDLE);

  // Next-state, burst bookkeeping and the write-port values for the next cycle.
  // NOTE: every signal assigned here gets a default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    n_state_d = c_state_q;
    num_d     = num_q;
    base_d    = base_q;
    cnt_d     = cnt_q;
    wr_d      = 1'b0;
    addr_d    = addr_q;
    data_d    = data_q;
    case (c_state_q)
      IDLE: begin
        if (start_i) begin
          num_d     = num_i;
          base_d    = base_addr_i;
          cnt_d     = '0;
          n_state_d = (num_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (beat) begin
          wr_d   = 1'b1;
          // Address wraps naturally at 2^AWIDTH; only the low counter bits matter.
          addr_d = base_q + cnt_q[AWIDTH-1:0];
          data_d = s_data_i;
          cnt_d  = cnt_q + CNT_BIT'(1);
          if (last_beat) begin
            n_state_d = DONE;
          end
        end
      end
      DONE: begin
        n_state_d = IDLE;
      end
      default: begin
        n_state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in progress.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_state_q <= IDLE;
      num_q     <= '0;
      base_q    <= '0;
      cnt_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      c_state_q <= n_state_d;
      num_q     <= num_d;
      base_q    <= base_d;
      cnt_q     <= cnt_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

`ifdef BRAM_WR_CHECKSUM_EN
  logic [DWIDTH-1:0] sum_q, sum_d;

  // Checksum restarts with each accepted start and accumulates every accepted word.
  always_comb begin
    sum_d = sum_q;
    if (start_take) begin
      sum_d = '0;
    end else if (beat) begin
      sum_d = sum_q + s_data_i;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum_o = sum_q;
`endif

  assign s_ready_o = (c_state_q == RUN);
  assign idle_o    = (c_state_q == IDLE);
  assign run_o     = (c_state_q == RUN);
  assign done_o    = (c_state_q == DONE);
  assign ce_o      = wr_q;
  assign we_o      = wr_q;
  assign addr_o    = addr_q;
  assign d_o       = data_q;

endmodule

// File: tb/tb_bram_wr_accessor.sv
// Testbench for bram_wr_accessor: a burst-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized bursts.
module tb_bram_wr_accessor;
  localparam int DWIDTH  = 32;
  localparam int AWIDTH  = 12;
  localparam int CNT_BIT = 31;

  logic               clk;
  logic               reset_n;
  logic               start_i;
  logic [CNT_BIT-1:0] num_i;
  logic [AWIDTH-1:0]  base_addr_i;
  logic               s_valid_i;
  logic               s_ready_o;
  logic [DWIDTH-1:0]  s_data_i;
  logic [AWIDTH-1:0]  addr_o;
  logic               ce_o;
  logic               we_o;
  logic [DWIDTH-1:0]  d_o;
  logic               idle_o;
  logic               run_o;
  logic               done_o;
`ifdef BRAM_WR_CHECKSUM_EN
  logic [DWIDTH-1:0]  checksum_o;
`endif

  bram_wr_accessor #(.DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .CNT_BIT(CNT_BIT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (start_i),
    .num_i      (num_i),
    .base_addr_i(base_addr_i),
    .s_valid_i  (s_valid_i),
    .s_ready_o  (s_ready_o),
    .s_data_i   (s_data_i),
    .addr_o     (addr_o),
    .ce_o       (ce_o),
    .we_o       (we_o),
    .d_o        (d_o),
`ifdef BRAM_WR_CHECKSUM_EN
    .checksum_o (checksum_o),
`endif
    .idle_o     (idle_o),
    .run_o      (run_o),
    .done_o     (done_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst-level reference model: is a burst open, how many words remain, which
  // address comes next, and what the port shows after each accepted word.
  logic               m_busy;
  logic               m_done;
  logic [CNT_BIT-1:0] m_left;
  logic [AWIDTH-1:0]  m_next_addr;
  logic               m_we;
  logic [AWIDTH-1:0]  m_addr;
  logic [DWIDTH-1:0]  m_data;
  logic [DWIDTH-1:0]  m_sum;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_left <= '0; m_next_addr <= '0;
      m_we <= 1'b0; m_addr <= '0; m_data <= '0; m_sum <= '0;
    end else begin
      m_we   <= 1'b0;
      m_done <= 1'b0;
      if (!m_busy && !m_done) begin
        if (start_i) begin
          m_next_addr <= base_addr_i;
          m_left      <= num_i;
          m_sum       <= '0;
          if (num_i == 0) m_done <= 1'b1;
          else            m_busy <= 1'b1;
        end
      end else if (m_busy && s_valid_i) begin
        m_we        <= 1'b1;
        m_addr      <= m_next_addr;
        m_data      <= s_data_i;
        m_next_addr <= m_next_addr + 1'b1;
        m_sum       <= m_sum + s_data_i;
        m_left      <= m_left - 1'b1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
        end
      end
    end
  end

  // Observed writes and events, logged for the literal checks.
  logic [AWIDTH-1:0] wr_addr[$];
  logic [DWIDTH-1:0] wr_data[$];
  int                done_cnt;
  int                ready_cnt;
  logic              done_we;
  logic [AWIDTH-1:0] done_addr;

  // Compare process: DUT against the model on every falling edge.
  always @(negedge clk) begin
    check("ready", s_ready_o, m_busy);
    check("idle",  idle_o,    !m_busy && !m_done);
    check("run",   run_o,     m_busy);
    check("done",  done_o,    m_done);
    check("we",    we_o,      m_we);
    check("ce",    ce_o,      m_we);
    check("addr",  addr_o,    m_addr);
    check("data",  d_o,       m_data);
`ifdef BRAM_WR_CHECKSUM_EN
    check("checksum", checksum_o, m_sum);
`endif
    if (we_o) begin
      wr_addr.push_back(addr_o);
      wr_data.push_back(d_o);
    end
    if (s_ready_o) ready_cnt++;
    if (done_o) begin
      done_cnt++;
      done_we   = we_o;
      done_addr = addr_o;
    end
  end

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    done_cnt  = 0;
    ready_cnt = 0;
    done_we   = 1'b0;
    done_addr = '0;
  endtask

  // Applies one set of inputs to the next rising edge and returns just after it.
  task automatic cyc(input logic st, input logic [CNT_BIT-1:0] n, input logic [AWIDTH-1:0] b,
                     input logic v, input logic [DWIDTH-1:0] d);
    start_i = st; num_i = n; base_addr_i = b; s_valid_i = v; s_data_i = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, 1'b0, '0);
  endtask

  initial begin
    logic [AWIDTH-1:0] wrap_exp[4];
    logic [2:0]        bp_pat;
    int                budget;
    int                n;

    reset_n = 1'b0;
    start_i = 1'b0; num_i = '0; base_addr_i = '0; s_valid_i = 1'b0; s_data_i = '0;
    clear_log();
    #12;
    check("reset_idle", idle_o, 1'b1);
    check("reset_ready", s_ready_o, 1'b0);
    check("reset_addr", addr_o, '0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst: 4 words at 0x010, valid held high (also high during the start).
    clear_log();
    cyc(1'b1, 4, 12'h010, 1'b1, 32'hDEAD);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 32'hA0 + i);
    idle_cycles(2);
    check("basic_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) begin
      check("basic_addr", wr_addr[i], 12'h010 + i);
      check("basic_data", wr_data[i], 32'hA0 + i);
    end
    check("basic_done_cnt", done_cnt, 1);
    check("basic_done_we", done_we, 1'b1);
    check("basic_done_addr", done_addr, 12'h013);
`ifdef BRAM_WR_CHECKSUM_EN
    check("basic_checksum", checksum_o, 32'h286);
`endif

    // Back-pressure gaps: valid pattern 1,0,0,1,0,1.
    clear_log();
    cyc(1'b1, 3, 12'h040, 1'b0, '0);
    cyc(1'b0, '0, '0, 1'b1, 32'h11);
    cyc(1'b0, '0, '0, 1'b0, 32'h99);
    cyc(1'b0, '0, '0, 1'b0, 32'h98);
    cyc(1'b0, '0, '0, 1'b1, 32'h22);
    cyc(1'b0, '0, '0, 1'b0, 32'h97);
    cyc(1'b0, '0, '0, 1'b1, 32'h33);
    idle_cycles(2);
    check("bp_nwr", wr_addr.size(), 3);
    check("bp_done_cnt", done_cnt, 1);
    if (wr_data.size() == 3) begin
      bp_pat = {wr_data[2] == 32'h33, wr_data[1] == 32'h22, wr_data[0] == 32'h11};
      check("bp_data", bp_pat, 3'b111);
    end

    // Address wrap from 0xFFE.
    clear_log();
    wrap_exp[0] = 12'hFFE; wrap_exp[1] = 12'hFFF; wrap_exp[2] = 12'h000; wrap_exp[3] = 12'h001;
    cyc(1'b1, 4, 12'hFFE, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 32'h500 + i);
    idle_cycles(2);
    check("wrap_nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr.size(); i++) check("wrap_addr", wr_addr[i], wrap_exp[i]);

    // Zero-length request: done in the next cycle, no writes.
    clear_log();
    cyc(1'b1, 0, 12'h123, 1'b1, 32'h1);
    check("zero_done_now", done_o, 1'b1);
    idle_cycles(2);
    check("zero_nwr", wr_addr.size(), 0);
    check("zero_done_cnt", done_cnt, 1);

    // Starts during RUN and during DONE are ignored.
    clear_log();
    cyc(1'b1, 2, 12'h200, 1'b0, '0);
    cyc(1'b1, 5, 12'h300, 1'b1, 32'hB0);
    cyc(1'b0, '0, '0, 1'b1, 32'hB1);
    check("ign_in_done", done_o, 1'b1);
    cyc(1'b1, 5, 12'h300, 1'b1, 32'hB2);
    idle_cycles(4);
    check("ign_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("ign_addr0", wr_addr[0], 12'h200);
      check("ign_addr1", wr_addr[1], 12'h201);
    end
    check("ign_done_cnt", done_cnt, 1);

    // Reset after the 3rd write of an 8-word burst.
    clear_log();
    cyc(1'b1, 8, 12'h050, 1'b0, '0);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 1'b1, 32'hC0 + i);
    check("mid_we_before", we_o, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", s_ready_o, 1'b0);
    check("mid_rst_we", we_o, 1'b0);
    check("mid_rst_ce", ce_o, 1'b0);
    check("mid_rst_addr", addr_o, '0);
    check("mid_rst_data", d_o, '0);
    check("mid_rst_idle", idle_o, 1'b1);
    check("mid_rst_run", run_o, 1'b0);
    check("mid_rst_done", done_o, 1'b0);
`ifdef BRAM_WR_CHECKSUM_EN
    check("mid_rst_checksum", checksum_o, '0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    clear_log();
    cyc(1'b1, 2, 12'h100, 1'b0, '0);
    for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 1'b1, 32'hD0 + i);
    idle_cycles(1);
    check("post_rst_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("post_rst_addr0", wr_addr[0], 12'h100);
      check("post_rst_addr1", wr_addr[1], 12'h101);
    end

    // Overrun protection: valid held for 5 cycles on a 2-word burst.
    clear_log();
    cyc(1'b1, 2, 12'h0A0, 1'b0, '0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, '0, 1'b1, 32'hE0 + i);
    idle_cycles(1);
    check("ovr_nwr", wr_addr.size(), 2);
    check("ovr_ready_cycles", ready_cnt, 2);

    // Randomized bursts with random gaps and stray starts.
    for (int b = 0; b < 40; b++) begin
      clear_log();
      n = $urandom_range(0, 6);
      cyc(1'b1, CNT_BIT'(n),
          ($urandom_range(0, 3) == 0) ? AWIDTH'(12'hFFC + $urandom_range(0, 3)) : AWIDTH'($urandom),
          $urandom_range(0, 1), $urandom);
      budget = 0;
      while ((m_busy || m_done) && budget < 200) begin
        cyc($urandom_range(0, 4) == 0, CNT_BIT'($urandom_range(0, 9)), AWIDTH'($urandom),
            $urandom_range(0, 9) < 7, $urandom);
        budget++;
      end
      if (budget >= 200) check("rand_timeout", 1'b1, 1'b0);
      check("rand_nwr", wr_addr.size(), n);
      check("rand_done_cnt", done_cnt, 1);
      idle_cycles($urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
